// File: rtl/level_sequencer.sv
// -----------------------------------------------------------------------------
// level_sequencer
//
// Game-flow controller for the ball motion datapath. It owns the ball
// controller's reset_level / pause / level inputs and steps the game through
// load -> ready -> play, handling ball-lost, level-complete, game-over and
// game-won conditions. Status outputs feed the score and text drawers.
//
// Optional build macro:
//   LEVEL_SEQUENCER_EXTRA_LIFE_EN - when defined, finishing a level that is
//   followed by another level grants one extra life, saturating at 7.
//   When undefined, lives change only on ball-lost and on restart.
//
// Ports:
//   clk                          in   system clock
//   resetN                       in   asynchronous active-low reset
//   startOfFrame                 in   one-cycle pulse per video frame
//   key5IsPressed                in   launch / restart key (level)
//   keyPauseIsPressed            in   pause toggle key (level)
//   collisionSmileyObstacleReal  in   one-cycle pulse per counted obstacle hit
//   smileyTopLeftY[10:0]         in   signed ball Y position in pixels
//   reset_level                  out  one-cycle level-load pulse
//   pause                        out  freezes ball motion (low only in PLAY)
//   level[3:0]                   out  current level, 0-based
//   lives[2:0]                   out  remaining lives
//   hitCount[7:0]                out  hits scored in the current level
//   gameOver                     out  high while in GAME_OVER
//   gameWon                      out  high while in GAME_WON
// -----------------------------------------------------------------------------
module level_sequencer #(
    parameter int NUM_LEVELS     = 4,
    parameter int INITIAL_LIVES  = 3,
    parameter int HITS_PER_LEVEL = 8,
    parameter int BOTTOM_Y       = 470,
    parameter int WAIT_FRAMES    = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        key5IsPressed,
    input  logic        keyPauseIsPressed,
    input  logic        collisionSmileyObstacleReal,
    input  logic [10:0] smileyTopLeftY,
    output logic        reset_level,
    output logic        pause,
    output logic [3:0]  level,
    output logic [2:0]  lives,
    output logic [7:0]  hitCount,
    output logic        gameOver,
    output logic        gameWon
);

    // -------------------------------------------------------------------------
    // Constants sized to the port widths
    // -------------------------------------------------------------------------
    localparam logic [3:0]         LAST_LEVEL  = 4'(NUM_LEVELS - 1);
    localparam logic [2:0]         LIVES_INIT  = 3'(INITIAL_LIVES);
    localparam logic [2:0]         LIVES_MAX   = 3'd7;
    localparam logic [7:0]         HITS_TARGET = 8'(HITS_PER_LEVEL);
    localparam logic signed [10:0] BOTTOM_LIM  = 11'(BOTTOM_Y);

    // Frame counter only needs to reach WAIT_FRAMES-1.
    localparam int                 FCW         = (WAIT_FRAMES > 2) ? $clog2(WAIT_FRAMES) : 1;
    localparam logic [FCW-1:0]     FRAME_LAST  = FCW'(WAIT_FRAMES - 1);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        READY,
        PLAY,
        PAUSED,
        BALL_LOST,
        LEVEL_DONE,
        GAME_OVER,
        GAME_WON
    } stateT;

    // -------------------------------------------------------------------------
    // State and next-state signals
    // -------------------------------------------------------------------------
    stateT          stateReg;
    stateT          stateNext;
    logic [3:0]     levelNext;
    logic [2:0]     livesNext;
    logic [7:0]     hitCountNext;
    logic [FCW-1:0] frameCountReg;
    logic [FCW-1:0] frameCountNext;

    logic           key5PrevReg;
    logic           keyPausePrevReg;
    logic           key5Edge;
    logic           keyPauseEdge;

    logic           hitCompletes;
    logic           ballIsLost;
    logic           frameWaitDone;
    logic [7:0]     hitCountInc;

    // -------------------------------------------------------------------------
    // Key edge detection: a held key produces a single one-cycle edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            key5PrevReg     <= 1'b0;
            keyPausePrevReg <= 1'b0;
        end else begin
            key5PrevReg     <= key5IsPressed;
            keyPausePrevReg <= keyPauseIsPressed;
        end
    end

    assign key5Edge     = key5IsPressed & ~key5PrevReg;
    assign keyPauseEdge = keyPauseIsPressed & ~keyPausePrevReg;

    // -------------------------------------------------------------------------
    // Event qualifiers used in PLAY
    // -------------------------------------------------------------------------
    assign hitCountInc   = hitCount + 8'd1;
    assign hitCompletes  = collisionSmileyObstacleReal && (hitCountInc == HITS_TARGET);
    assign ballIsLost    = startOfFrame && ($signed(smileyTopLeftY) > BOTTOM_LIM);
    assign frameWaitDone = startOfFrame && (frameCountReg == FRAME_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext      = stateReg;
        levelNext      = level;
        livesNext      = lives;
        hitCountNext   = hitCount;
        frameCountNext = frameCountReg;

        case (stateReg)
            IDLE: begin
                stateNext = LOAD;
            end

            LOAD: begin
                hitCountNext = 8'd0;
                stateNext    = READY;
            end

            READY: begin
                if (key5Edge) begin
                    stateNext = PLAY;
                end
            end

            PLAY: begin
                // A non-completing hit still counts even when the ball is lost
                // in the same cycle; the count is cleared at the next LOAD.
                if (collisionSmileyObstacleReal && (hitCount != HITS_TARGET)) begin
                    hitCountNext = hitCountInc;
                end

                // Priority: completing hit > ball lost > pause edge.
                if (hitCompletes) begin
                    stateNext = LEVEL_DONE;
                end else if (ballIsLost) begin
                    if (lives != 3'd0) begin
                        livesNext = lives - 3'd1;
                    end
                    stateNext = (lives <= 3'd1) ? GAME_OVER : BALL_LOST;
                end else if (keyPauseEdge) begin
                    stateNext = PAUSED;
                end
            end

            PAUSED: begin
                if (keyPauseEdge) begin
                    stateNext = PLAY;
                end
            end

            BALL_LOST: begin
                if (frameWaitDone) begin
                    stateNext = LOAD;
                end else if (startOfFrame) begin
                    frameCountNext = frameCountReg + FCW'(1);
                end
            end

            LEVEL_DONE: begin
                if (frameWaitDone) begin
                    if (level == LAST_LEVEL) begin
                        stateNext = GAME_WON;
                    end else begin
                        // Level is advanced on the way into LOAD so it is
                        // already stable while reset_level is high.
                        levelNext = level + 4'd1;
`ifdef LEVEL_SEQUENCER_EXTRA_LIFE_EN
                        livesNext = (lives == LIVES_MAX) ? lives : lives + 3'd1;
`else
                        livesNext = lives;
`endif
                        stateNext = LOAD;
                    end
                end else if (startOfFrame) begin
                    frameCountNext = frameCountReg + FCW'(1);
                end
            end

            GAME_OVER, GAME_WON: begin
                if (key5Edge) begin
                    levelNext = 4'd0;
                    livesNext = LIVES_INIT;
                    stateNext = LOAD;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        // Every state change starts the wait counter from zero.
        if (stateNext != stateReg) begin
            frameCountNext = '0;
        end
    end

    // -------------------------------------------------------------------------
    // State register. Outputs are decoded from the next state so they are
    // registered and aligned with the state they describe.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateReg      <= IDLE;
            level         <= 4'd0;
            lives         <= LIVES_INIT;
            hitCount      <= 8'd0;
            frameCountReg <= '0;
            reset_level   <= 1'b0;
            pause         <= 1'b1;
            gameOver      <= 1'b0;
            gameWon       <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            level         <= levelNext;
            lives         <= livesNext;
            hitCount      <= hitCountNext;
            frameCountReg <= frameCountNext;
            reset_level   <= (stateNext == LOAD);
            pause         <= (stateNext != PLAY);
            gameOver      <= (stateNext == GAME_OVER);
            gameWon       <= (stateNext == GAME_WON);
        end
    end

endmodule

// File: tb/tb_level_sequencer.sv
// -----------------------------------------------------------------------------
// tb_level_sequencer
//
// Directed bench for level_sequencer with default parameters. Inputs are
// driven 1 ns after the rising edge and outputs are sampled at the same
// point. Expected values are hand-derived; lives are tracked in expLives.
// -----------------------------------------------------------------------------
module tb_level_sequencer;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        key5IsPressed;
    logic        keyPauseIsPressed;
    logic        collisionSmileyObstacleReal;
    logic [10:0] smileyTopLeftY;
    logic        reset_level;
    logic        pause;
    logic [3:0]  level;
    logic [2:0]  lives;
    logic [7:0]  hitCount;
    logic        gameOver;
    logic        gameWon;

    int checks     = 0;
    int errors     = 0;
    int loadPulses = 0;
    int loadsBefore;
    int expLives;
    int expLevel;

    level_sequencer dut (
        .clk                         (clk),
        .resetN                      (resetN),
        .startOfFrame                (startOfFrame),
        .key5IsPressed               (key5IsPressed),
        .keyPauseIsPressed           (keyPauseIsPressed),
        .collisionSmileyObstacleReal (collisionSmileyObstacleReal),
        .smileyTopLeftY              (smileyTopLeftY),
        .reset_level                 (reset_level),
        .pause                       (pause),
        .level                       (level),
        .lives                       (lives),
        .hitCount                    (hitCount),
        .gameOver                    (gameOver),
        .gameWon                     (gameWon)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count clock cycles during which reset_level is high.
    always @(posedge clk) begin
        if (reset_level === 1'b1) loadPulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-22s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseFrame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
    endtask

    task automatic frames(input int n);
        repeat (n) pulseFrame();
    endtask

    task automatic hit();
        collisionSmileyObstacleReal = 1'b1;
        tick();
        collisionSmileyObstacleReal = 1'b0;
        tick();
    endtask

    task automatic pressKey5();
        key5IsPressed = 1'b1;
        tick(3);
        key5IsPressed = 1'b0;
        tick();
    endtask

    task automatic pressPause();
        keyPauseIsPressed = 1'b1;
        tick(3);
        keyPauseIsPressed = 1'b0;
        tick();
    endtask

    initial begin
        resetN                      = 1'b0;
        startOfFrame                = 1'b0;
        key5IsPressed               = 1'b0;
        keyPauseIsPressed           = 1'b0;
        collisionSmileyObstacleReal = 1'b0;
        smileyTopLeftY              = 11'd100;
        expLives                    = 3;
        expLevel                    = 0;
        tick(3);

        // Reset values
        chk("rst_reset_level", reset_level, 0);
        chk("rst_pause", pause, 1);
        chk("rst_level", level, 0);
        chk("rst_lives", lives, 3);
        chk("rst_hitCount", hitCount, 0);
        chk("rst_gameOver", gameOver, 0);
        chk("rst_gameWon", gameWon, 0);

        // Release: IDLE -> LOAD -> READY
        resetN = 1'b1;
        tick();
        chk("load_reset_level", reset_level, 1);
        chk("load_level", level, 0);
        chk("load_lives", lives, 3);
        tick();
        chk("ready_reset_level", reset_level, 0);
        chk("ready_pause", pause, 1);
        chk("load_pulse_count", loadPulses, 1);

        // Held launch key: exactly one transition to PLAY
        key5IsPressed = 1'b1;
        tick(10);
        chk("play_pause", pause, 0);
        chk("held_key_no_load", loadPulses, 1);
        key5IsPressed = 1'b0;
        tick();

        // Eight hits complete level 0
        repeat (7) hit();
        chk("hits7_count", hitCount, 7);
        chk("hits7_pause", pause, 0);
        hit();
        chk("hits8_count", hitCount, 8);
        chk("hits8_pause", pause, 1);
        frames(59);
        chk("done59_level", level, 0);
        chk("done59_no_load", loadPulses, 1);
        frames(1);
        expLevel = 1;
`ifdef LEVEL_SEQUENCER_EXTRA_LIFE_EN
        expLives = 4;
`endif
        chk("done60_level", level, expLevel);
        chk("done60_hitCount", hitCount, 0);
        chk("done60_load_count", loadPulses, 2);
        chk("done60_lives", lives, expLives);

        // Ball-lost threshold on level 1
        pressKey5();
        smileyTopLeftY = 11'd470;
        pulseFrame();
        chk("y470_lives", lives, expLives);
        chk("y470_pause", pause, 0);
        smileyTopLeftY = 11'd471;
        pulseFrame();
        smileyTopLeftY = 11'd100;
        expLives--;
        chk("y471_lives", lives, expLives);
        chk("y471_pause", pause, 1);
        frames(60);
        chk("lost_reload_level", level, expLevel);
        chk("lost_reload_count", loadPulses, 3);
        chk("lost_reload_lives", lives, expLives);

        // Pause toggling; hits ignored while paused
        pressKey5();
        hit();
        chk("pre_pause_hits", hitCount, 1);
        pressPause();
        chk("paused_pause", pause, 1);
        hit();
        hit();
        chk("paused_hits", hitCount, 1);
        pressPause();
        chk("unpaused_pause", pause, 0);

        // Completing hit and ball-lost in the same cycle: hit wins
        repeat (6) hit();
        chk("same_pre_hits", hitCount, 7);
        collisionSmileyObstacleReal = 1'b1;
        startOfFrame                = 1'b1;
        smileyTopLeftY              = 11'd471;
        tick();
        collisionSmileyObstacleReal = 1'b0;
        startOfFrame                = 1'b0;
        smileyTopLeftY              = 11'd100;
        tick();
        chk("same_hits", hitCount, 8);
        chk("same_lives", lives, expLives);
        chk("same_pause", pause, 1);
        chk("same_gameOver", gameOver, 0);
        frames(60);
        expLevel = 2;
`ifdef LEVEL_SEQUENCER_EXTRA_LIFE_EN
        expLives++;
`endif
        chk("lvl2_level", level, expLevel);
        chk("lvl2_lives", lives, expLives);

        // Lose every remaining life
        while (expLives > 0) begin
            pressKey5();
            smileyTopLeftY = 11'd471;
            pulseFrame();
            smileyTopLeftY = 11'd100;
            expLives--;
            chk("loss_lives", lives, expLives);
            if (expLives > 0) frames(60);
        end
        chk("over_gameOver", gameOver, 1);
        chk("over_lives", lives, 0);
        chk("over_level", level, 2);
        chk("over_pause", pause, 1);

        // Restart from GAME_OVER
        loadsBefore   = loadPulses;
        key5IsPressed = 1'b1;
        tick();
        chk("restart_reset_level", reset_level, 1);
        chk("restart_level", level, 0);
        chk("restart_lives", lives, 3);
        chk("restart_gameOver", gameOver, 0);
        key5IsPressed = 1'b0;
        tick();
        chk("restart_one_load", loadPulses, loadsBefore + 1);
        expLives = 3;
        expLevel = 0;

        // Play all four levels to a win
        for (int lv = 0; lv < 4; lv++) begin
            pressKey5();
            repeat (8) hit();
            if (lv < 3) begin
                frames(60);
                expLevel++;
`ifdef LEVEL_SEQUENCER_EXTRA_LIFE_EN
                if (expLives < 7) expLives++;
`endif
                chk("win_run_level", level, expLevel);
                chk("win_run_lives", lives, expLives);
            end else begin
                frames(59);
                chk("won59_gameWon", gameWon, 0);
                frames(1);
                chk("won60_gameWon", gameWon, 1);
                chk("won60_level", level, 3);
                chk("won60_pause", pause, 1);
                chk("won60_lives", lives, expLives);
            end
        end

        // Asynchronous reset in the middle of a cycle
        #3;
        resetN = 1'b0;
        #1;
        chk("async_gameWon", gameWon, 0);
        chk("async_level", level, 0);
        chk("async_pause", pause, 1);
        chk("async_lives", lives, 3);
        tick();
        loadsBefore = loadPulses;
        resetN      = 1'b1;
        tick(5);
        chk("rerelease_one_load", loadPulses, loadsBefore + 1);
        chk("rerelease_pause", pause, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
